// File: rtl/alu_pkg.sv
// Shared alu opcode encodings and request bundle.
// Used by the alu, the arbiter top and benches.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SLT = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;

  typedef struct packed {
    logic [2:0]  opsel;
    logic        sub;
    logic        uns;
    logic        arith;
    logic [31:0] op1;
    logic [31:0] op2;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit alu; carry-out dropped.
// opsel 3'b111 is unassigned and yields zero.
module alu
  import alu_pkg::*;
(
  input  logic [2:0]  i_opsel,
  input  logic        i_sub,
  input  logic        i_unsigned,
  input  logic        i_arith,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic [31:0] o_result
);

  logic [4:0] w_sh;
  logic       w_lt;

  assign w_sh = i_op2[4:0];

  // signed or unsigned less-than
  always_comb begin
    w_lt = 1'b0;
    if (i_unsigned) w_lt = i_op1 < i_op2;
    else            w_lt = $signed(i_op1) < $signed(i_op2);
  end

  // result select by opsel
  always_comb begin
    o_result = '0;
    unique case (i_opsel)
      OP_ADD: o_result = i_sub ? i_op1 - i_op2 : i_op1 + i_op2;
      OP_SLT: o_result = {31'd0, w_lt};
      OP_SLL: o_result = i_op1 << w_sh;
      OP_SRL: o_result = i_arith ? 32'($signed(i_op1) >>> w_sh)
                                 : i_op1 >> w_sh;
      OP_XOR: o_result = i_op1 ^ i_op2;
      OP_OR:  o_result = i_op1 | i_op2;
      OP_AND: o_result = i_op1 & i_op2;
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at r_ptr and wraps;
// pointer moves past the winner on every grant.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id
);

  logic [ID_W-1:0] r_ptr;
  logic            w_found;
  int              w_idx;

  // first requester at or after r_ptr, wrapping
  always_comb begin
    o_grant    = '0;
    o_grant_id = r_ptr;
    w_found    = 1'b0;
    w_idx      = 0;
    if (i_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_idx = (int'(r_ptr) + i) % NUM_REQ;
        if (!w_found && i_req[w_idx]) begin
          w_found         = 1'b1;
          o_grant[w_idx]  = 1'b1;
          o_grant_id      = ID_W'(w_idx);
        end
      end
    end
  end

  // advance pointer past the winner; idle cycles hold it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (|o_grant) begin
      if (o_grant_id == ID_W'(NUM_REQ - 1)) r_ptr <= '0;
      else                                   r_ptr <= o_grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu among NUM_REQ requesters with a
// one-entry registered response buffer.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic [3*NUM_REQ-1:0]  i_req_opsel,
  input  logic [NUM_REQ-1:0]    i_req_sub,
  input  logic [NUM_REQ-1:0]    i_req_unsigned,
  input  logic [NUM_REQ-1:0]    i_req_arith,
  input  logic [32*NUM_REQ-1:0] i_req_op1,
  input  logic [32*NUM_REQ-1:0] i_req_op2,
  output logic [NUM_REQ-1:0]    o_rsp_valid,
  input  logic [NUM_REQ-1:0]    i_rsp_ready,
  output logic [31:0]           o_rsp_result
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [31:0]        r_result;

  logic               w_can_accept;
  logic               w_drain;
  logic               w_accept;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gid;
  alu_req_t           w_req;
  logic [31:0]        w_alu_res;

  // reset gates grants so ready drops without a clock
  assign w_drain      = r_rsp_valid && i_rsp_ready[r_rsp_id];
  assign w_can_accept = i_rst_n && (!r_rsp_valid || w_drain);
  assign w_accept     = |w_grant;
  assign o_req_ready  = w_grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_req      (i_req_valid),
    .i_en       (w_can_accept),
    .o_grant    (w_grant),
    .o_grant_id (w_gid)
  );

  // operand mux; idle cycles select the pointer
  always_comb begin
    w_req.opsel = i_req_opsel[3*w_gid +: 3];
    w_req.sub   = i_req_sub[w_gid];
    w_req.uns   = i_req_unsigned[w_gid];
    w_req.arith = i_req_arith[w_gid];
    w_req.op1   = i_req_op1[32*w_gid +: 32];
    w_req.op2   = i_req_op2[32*w_gid +: 32];
  end

  alu u_alu (
    .i_opsel    (w_req.opsel),
    .i_sub      (w_req.sub),
    .i_unsigned (w_req.uns),
    .i_arith    (w_req.arith),
    .i_op1      (w_req.op1),
    .i_op2      (w_req.op2),
    .o_result   (w_alu_res)
  );

  // response buffer: reload on accept, else clear on drain
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_result    <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gid;
      r_result    <= w_alu_res;
    end else if (w_drain) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // one-hot response valid for the buffered owner
  always_comb begin
    o_rsp_valid = '0;
    if (r_rsp_valid) o_rsp_valid[r_rsp_id] = 1'b1;
  end

  assign o_rsp_result = r_result;

endmodule
